// File: rtl/sqrd_sequencer.sv
// sqrd_sequencer: stage controller for sorted-QR preprocessing of the 8x8
// real-valued channel matrix. It owns the H / column-norm / column-order
// working registers. Each stage makes one pass through the external
// permutation datapath, then a req/ack round trip through the shared
// orthogonalize/norm-update engine.
//
// Optional feature: define SQRD_SWAP_CNT_EN to add swap_cnt_o. This counts
// the stages that performed a real column exchange, and saturates at 7.
//
// Bit packing:
//   - H element (col c, row r) lives at [(c*8+r)*WL +: WL].
//   - Norm slot j lives at [j*COLNORM_WL +: COLNORM_WL].
//   - Order slot j lives at [j*3 +: 3].
//
// perm_N_o is 3 bits wide. N = 8 (stage 0) therefore appears as 3'd0.

`ifndef WL
`define WL 16
`endif
`ifndef COLNORM_WL
`define COLNORM_WL 20
`endif

module sqrd_sequencer #(
  parameter int NSTAGE = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  output logic                      in_ready_o,
  input  logic [64*`WL-1:0]         Hmatrix_i,
  input  logic [8*`COLNORM_WL-1:0]  colnorm_i,
  input  logic [23:0]               colorder_i,
  output logic [2:0]                perm_N_o,
  output logic [64*`WL-1:0]         perm_H_o,
  output logic [8*`COLNORM_WL-1:0]  perm_norm_o,
  output logic [23:0]               perm_order_o,
  input  logic [64*`WL-1:0]         perm_H_i,
  input  logic [8*`COLNORM_WL-1:0]  perm_norm_i,
  input  logic [23:0]               perm_order_i,
  output logic                      upd_req_o,
  output logic [2:0]                upd_col_o,
  output logic [64*`WL-1:0]         upd_H_o,
  input  logic                      upd_ack_i,
  input  logic [64*`WL-1:0]         upd_H_i,
  input  logic [8*`COLNORM_WL-1:0]  upd_norm_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [64*`WL-1:0]         Hmatrix_o,
  output logic [23:0]               colorder_o,
`ifdef SQRD_SWAP_CNT_EN
  output logic [2:0]                swap_cnt_o,
`endif
  output logic                      busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PERM = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Last stage index; NSTAGE <= 7 keeps this within the 3-bit k range.
  localparam logic [2:0] K_LAST = 3'(NSTAGE - 1);

  logic [1:0]                 state_reg;
  logic [2:0]                 k_reg;
  logic [64*`WL-1:0]          h_reg;
  logic [8*`COLNORM_WL-1:0]   norm_reg;
  logic [23:0]                order_reg;

  logic accept;
  assign accept = (state_reg == S_IDLE) && start_i;

  // Stage sequencing: IDLE -> (PERM -> UPD) x NSTAGE -> DONE -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      k_reg     <= 3'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            k_reg     <= 3'd0;
            state_reg <= S_PERM;
          end
        end
        S_PERM: state_reg <= S_UPD;
        S_UPD: begin
          if (upd_ack_i) begin
            if (k_reg == K_LAST) begin
              state_reg <= S_DONE;
            end else begin
              k_reg     <= k_reg + 3'd1;
              state_reg <= S_PERM;
            end
          end
        end
        default: begin
          if (out_ready_i) state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Working registers:
  //   - loaded on accept;
  //   - replaced by the permutation result in PERM;
  //   - H/norms replaced by the engine result on the ack cycle in UPD.
  // The column order is only ever changed by the permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_reg     <= '0;
      norm_reg  <= '0;
      order_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            h_reg     <= Hmatrix_i;
            norm_reg  <= colnorm_i;
            order_reg <= colorder_i;
          end
        end
        S_PERM: begin
          h_reg     <= perm_H_i;
          norm_reg  <= perm_norm_i;
          order_reg <= perm_order_i;
        end
        S_UPD: begin
          if (upd_ack_i) begin
            h_reg    <= upd_H_i;
            norm_reg <= upd_norm_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Status and handshake outputs decode directly from the state register.
  // Because of this, an asynchronous reset drops upd_req_o immediately.
  assign in_ready_o  = (state_reg == S_IDLE);
  assign busy_o      = (state_reg != S_IDLE);
  assign upd_req_o   = (state_reg == S_UPD);
  assign out_valid_o = (state_reg == S_DONE);
  assign upd_col_o   = k_reg;

  // N = 8 - k; the 3-bit port wraps 8 to 0.
  assign perm_N_o     = 3'(4'd8 - {1'b0, k_reg});
  assign perm_H_o     = h_reg;
  assign perm_norm_o  = norm_reg;
  assign perm_order_o = order_reg;
  assign upd_H_o      = h_reg;
  assign Hmatrix_o    = h_reg;
  assign colorder_o   = order_reg;

`ifdef SQRD_SWAP_CNT_EN
  // Per-slot views of the current and permuted column order.
  logic [2:0] cur_slot [8];
  logic [2:0] nxt_slot [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_slot
    assign cur_slot[gi] = order_reg[3*gi +: 3];
    assign nxt_slot[gi] = perm_order_i[3*gi +: 3];
  end

  logic       swap_hit;
  logic [2:0] swap_cnt_reg;

  // Slot k (= 8-N) changing its column index means a real exchange happened.
  assign swap_hit = (state_reg == S_PERM) && (cur_slot[k_reg] != nxt_slot[k_reg]);

  // Saturating exchange counter, cleared on each accepted channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_cnt_reg <= 3'd0;
    end else if (accept) begin
      swap_cnt_reg <= 3'd0;
    end else if (swap_hit && (swap_cnt_reg != 3'd7)) begin
      swap_cnt_reg <= swap_cnt_reg + 3'd1;
    end
  end

  assign swap_cnt_o = swap_cnt_reg;
`endif

endmodule

// File: tb/tb_sqrd_sequencer.sv
// tb_sqrd_sequencer: directed bench for sqrd_sequencer.
//
// The bench provides a behavioural permutation datapath and update engine.
// The update engine has selectable per-stage latency, stray acks and an
// echo mode. Expected outputs are queued at accept time and checked when
// the DUT hands the result off.

`timescale 1ns/1ps
`ifndef WL
`define WL 16
`endif
`ifndef COLNORM_WL
`define COLNORM_WL 20
`endif

module tb_sqrd_sequencer;
  parameter int NSTAGE = 7;
  localparam int W  = `WL;
  localparam int CW = `COLNORM_WL;
  localparam int HW = 64 * W;
  localparam int NW = 8 * CW;

  typedef struct packed {
    logic [HW-1:0] h;
    logic [NW-1:0] n;
    logic [23:0]   o;
  } chan_t;

  typedef struct {
    chan_t c;
    int    swaps;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, in_ready_o;
  logic [HW-1:0] Hmatrix_i, perm_H_o, perm_H_i, upd_H_o, upd_H_i, Hmatrix_o;
  logic [NW-1:0] colnorm_i, perm_norm_o, perm_norm_i, upd_norm_i;
  logic [23:0]   colorder_i, perm_order_o, perm_order_i, colorder_o;
  logic [2:0]    perm_N_o, upd_col_o;
  logic          upd_req_o, upd_ack_i, out_valid_o, out_ready_i, busy_o;
`ifdef SQRD_SWAP_CNT_EN
  logic [2:0]    swap_cnt_o;
`endif

  int    n_checks = 0;
  int    n_errors = 0;
  int    n_out    = 0;
  int    req_cnt  = 0;
  int    stall_k, stall_lat, exp_lat;
  bit    echo_mode, stray_en;
  int    stage_q[$];
  exp_t  exp_q[$];
  chan_t last_exp;

  always #5 clk = ~clk;

  sqrd_sequencer #(.NSTAGE(NSTAGE)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .in_ready_o(in_ready_o),
    .Hmatrix_i(Hmatrix_i), .colnorm_i(colnorm_i), .colorder_i(colorder_i),
    .perm_N_o(perm_N_o), .perm_H_o(perm_H_o), .perm_norm_o(perm_norm_o),
    .perm_order_o(perm_order_o), .perm_H_i(perm_H_i), .perm_norm_i(perm_norm_i),
    .perm_order_i(perm_order_i), .upd_req_o(upd_req_o), .upd_col_o(upd_col_o),
    .upd_H_o(upd_H_o), .upd_ack_i(upd_ack_i), .upd_H_i(upd_H_i),
    .upd_norm_i(upd_norm_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .Hmatrix_o(Hmatrix_o), .colorder_o(colorder_o),
`ifdef SQRD_SWAP_CNT_EN
    .swap_cnt_o(swap_cnt_o),
`endif
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sorted QR picks the smallest-norm column among slots k..7 (first on ties).
  function automatic int min_slot(input logic [NW-1:0] n, input int k);
    int m;
    m = k;
    for (int j = k + 1; j < 8; j++)
      if (n[j*CW +: CW] < n[m*CW +: CW]) m = j;
    return m;
  endfunction

  function automatic chan_t perm_model(input chan_t c, input int k);
    chan_t r;
    int    m;
    r = c;
    m = min_slot(c.n, k);
    if (m != k) begin
      r.n[k*CW +: CW] = c.n[m*CW +: CW];
      r.n[m*CW +: CW] = c.n[k*CW +: CW];
      r.o[k*3 +: 3]   = c.o[m*3 +: 3];
      r.o[m*3 +: 3]   = c.o[k*3 +: 3];
      for (int row = 0; row < 8; row++) begin
        r.h[(k*8+row)*W +: W] = c.h[(m*8+row)*W +: W];
        r.h[(m*8+row)*W +: W] = c.h[(k*8+row)*W +: W];
      end
    end
    return r;
  endfunction

  // Stand-in engine: perturbs the columns and norms right of column k.
  function automatic chan_t eng_model(input chan_t c, input int k);
    chan_t r;
    r = c;
    for (int j = k + 1; j < 8; j++) begin
      r.n[j*CW +: CW] = c.n[j*CW +: CW] + CW'((j*3 + k) % 5);
      for (int row = 0; row < 8; row++)
        r.h[(j*8+row)*W +: W] = c.h[(j*8+row)*W +: W] + W'(k + 1);
    end
    return r;
  endfunction

  // Zero-latency permutation datapath.
  chan_t perm_in, perm_out;
  int    perm_k;
  always_comb begin
    perm_in  = {perm_H_o, perm_norm_o, perm_order_o};
    perm_k   = (perm_N_o == 3'd0) ? 0 : 8 - int'(perm_N_o);
    perm_out = perm_model(perm_in, perm_k);
  end
  assign perm_H_i     = perm_out.h;
  assign perm_norm_i  = perm_out.n;
  assign perm_order_i = perm_out.o;

  // Update engine: acks after a per-stage latency. While the request is low,
  // it can fire stray acks carrying corrupted data.
  chan_t eng_in, eng_out;
  int    eng_k, eng_lat;
  always_comb begin
    upd_ack_i  = 1'b0;
    upd_H_i    = '0;
    upd_norm_i = '0;
    eng_in     = {upd_H_o, perm_norm_o, perm_order_o};
    eng_k      = int'(upd_col_o);
    eng_lat    = (eng_k == stall_k) ? stall_lat : 1;
    eng_out    = echo_mode ? eng_in : eng_model(eng_in, eng_k);
    if (upd_req_o) begin
      upd_ack_i  = (req_cnt == eng_lat - 1);
      upd_H_i    = eng_out.h;
      upd_norm_i = eng_out.n;
    end else begin
      upd_ack_i  = stray_en;
      upd_H_i    = ~upd_H_o;
      upd_norm_i = ~perm_norm_o;
    end
  end

  always @(posedge clk) req_cnt <= (upd_req_o && !upd_ack_i) ? req_cnt + 1 : 0;

  // Monitor: stage order, request hold time and output scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy_o && !upd_req_o && !out_valid_o) begin
        chk("perm_stage_expected", int'(stage_q.size() > 0), 1);
        if (stage_q.size() > 0) chk("perm_N", int'(perm_N_o), (8 - stage_q[0]) % 8);
      end
      if (upd_req_o) begin
        chk("upd_stage_expected", int'(stage_q.size() > 0), 1);
        if (stage_q.size() > 0) begin
          chk("upd_col", int'(upd_col_o), stage_q[0]);
          if (upd_ack_i) begin
            chk("upd_req_hold", req_cnt + 1, (stage_q[0] == stall_k) ? stall_lat : 1);
            void'(stage_q.pop_front());
          end
        end
      end
      if (out_valid_o && out_ready_i) begin
        chk("out_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          n_out++;
          $display("txn %0d: result order=%06h swaps=%0d", n_out, colorder_o, e.swaps);
          chk_w("out_H", Hmatrix_o, e.c.h);
          chk("out_order", int'(colorder_o), int'(e.c.o));
`ifdef SQRD_SWAP_CNT_EN
          chk("swap_cnt", int'(swap_cnt_o), e.swaps);
`endif
        end
      end
    end
  end

  task automatic accept_channel(input chan_t c);
    exp_t  e;
    chan_t m;
    int    sw, lat;
    m   = c;
    sw  = 0;
    lat = 1;
    for (int k = 0; k < NSTAGE; k++) begin
      if (min_slot(m.n, k) != k && sw < 7) sw++;
      m = perm_model(m, k);
      if (!echo_mode) m = eng_model(m, k);
      lat += 1 + ((k == stall_k) ? stall_lat : 1);
      stage_q.push_back(k);
    end
    e.c = m;
    e.swaps = sw;
    exp_q.push_back(e);
    last_exp = m;
    exp_lat = lat;
    for (int i = 0; i < 50 && !in_ready_o; i++) begin @(posedge clk); #1; end
    chk("ready_before_start", int'(in_ready_o), 1);
    Hmatrix_i  = c.h;
    colnorm_i  = c.n;
    colorder_i = c.o;
    start_i    = 1'b1;
    @(posedge clk); #1;
    start_i    = 1'b0;
    $display("txn accept: order_in=%06h expected_latency=%0d", c.o, lat);
    chk("busy_after_accept", int'(busy_o), 1);
  endtask

  // Latency counts clock edges from the accept edge (inclusive) up to the
  // edge after which out_valid_o is seen high.
  task automatic wait_valid();
    int cyc;
    cyc = 1;
    while (!out_valid_o && cyc < 500) begin @(posedge clk); #1; cyc++; end
    chk("out_valid_seen", int'(out_valid_o), 1);
    chk("latency", cyc, exp_lat);
    chk("ready_low_in_done", int'(in_ready_o), 0);
  endtask

  // Hold off the downstream side for a number of cycles while poking
  // start_i, then complete the handshake.
  task automatic release_out(input int hold);
    for (int i = 0; i < hold; i++) begin
      start_i    = (i % 3 == 0);
      Hmatrix_i  = ~Hmatrix_i;
      colorder_i = ~colorder_i;
      @(posedge clk); #1;
      chk("bp_valid", int'(out_valid_o), 1);
      chk("bp_ready", int'(in_ready_o), 0);
      chk_w("bp_H", Hmatrix_o, last_exp.h);
      chk("bp_order", int'(colorder_o), int'(last_exp.o));
    end
    start_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    chk("idle_ready", int'(in_ready_o), 1);
    chk("idle_valid", int'(out_valid_o), 0);
    chk("idle_busy", int'(busy_o), 0);
  endtask

  function automatic chan_t make_chan(input int norm_mode);
    chan_t c;
    for (int i = 0; i < 64; i++) c.h[i*W +: W] = W'($urandom);
    for (int j = 0; j < 8; j++) begin
      c.o[j*3 +: 3] = 3'(j);
      case (norm_mode)
        0:       c.n[j*CW +: CW] = CW'(j + 1);
        1:       c.n[j*CW +: CW] = CW'(8 - j);
        default: c.n[j*CW +: CW] = CW'($urandom_range(1, 1000));
      endcase
    end
    return c;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    chan_t c;
    int    rst_k;
    rst = 1'b1; start_i = 1'b0; out_ready_i = 1'b0;
    Hmatrix_i = '0; colnorm_i = '0; colorder_i = '0;
    echo_mode = 1'b1; stray_en = 1'b0; stall_k = 99; stall_lat = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_upd_req", int'(upd_req_o), 0);
    chk("rst_out_valid", int'(out_valid_o), 0);
    chk("rst_order", int'(colorder_o), 0);
    chk_w("rst_H", Hmatrix_o, '0);
    chk("rst_upd_col", int'(upd_col_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity: ascending norms, echoing engine; no exchanges expected.
    c = make_chan(0);
    accept_channel(c);
    wait_valid();
    chk("identity_order", int'(colorder_o), int'(c.o));
    release_out(0);

    // Reverse norms with the modifying engine.
    echo_mode = 1'b0;
    accept_channel(make_chan(1));
    wait_valid();
    release_out(0);

    // Engine stall at k=3, stray acks outside UPD, then back-pressure.
    stall_k = 3; stall_lat = 5; stray_en = 1'b1;
    accept_channel(make_chan(2));
    wait_valid();
    release_out(10);
    stray_en = 1'b0; stall_k = 99; stall_lat = 1;

    // Reset while the engine is busy on an intermediate stage.
    rst_k = (NSTAGE > 2) ? 2 : NSTAGE - 1;
    stall_k = rst_k; stall_lat = 6;
    accept_channel(make_chan(2));
    for (int i = 0; i < 100 && !(upd_req_o && int'(upd_col_o) == rst_k); i++) begin
      @(posedge clk); #1;
    end
    chk("reached_reset_stage", int'(upd_req_o && int'(upd_col_o) == rst_k), 1);
    rst = 1'b1;
    #1;
    chk("midrst_upd_req", int'(upd_req_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_ready", int'(in_ready_o), 1);
    chk("midrst_order", int'(colorder_o), 0);
    stage_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    stall_k = 99; stall_lat = 1;
    @(posedge clk); #1;

    // Clean run after reset.
    accept_channel(make_chan(2));
    wait_valid();
    release_out(2);
    chk("all_outputs_seen", n_out, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sqrd_sequencer.md
Name: sqrd_sequencer

Overview:
- Controls sorted-QR (SQRD) preprocessing for the 4x4 complex MIMO detector, using the 8x8 real-valued H.
- Owns the working registers for H, column norms and column order, and steps through the column stages in order.
- At each stage it drives the shared combinational column-permutation datapath, then a shared multi-cycle orthogonalize/norm-update engine through a req/ack handshake.
- Its output (permuted/reduced H plus final column order) feeds the detector front end.

Parameters:
NSTAGE, 7, number of permute+update stages (1..7); stage k permutes with N = 8-k remaining columns.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start_i  in  1  new channel valid; accepted when start_i && in_ready_o
in_ready_o  out  1  high only in IDLE
Hmatrix_i  in  64*`WL  initial H
colnorm_i  in  8*`COLNORM_WL  initial column norms
colorder_i  in  24  initial order (normally {3'd7,...,3'd0})
perm_N_o  out  3  N for permutation datapath (8-k)
perm_H_o / perm_norm_o / perm_order_o  out  as inputs  working registers to permutation datapath
perm_H_i / perm_norm_i / perm_order_i  in  as inputs  permutation datapath results (zero latency)
upd_req_o  out  1  update request
upd_col_o  out  3  column index k being orthogonalized
upd_H_o  out  64*`WL  permuted H to engine (working register)
upd_ack_i  in  1  engine done; upd_H_i/upd_norm_i valid this cycle
upd_H_i  in  64*`WL  updated H
upd_norm_i  in  8*`COLNORM_WL  updated norms
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts
Hmatrix_o  out  64*`WL  final H (working register)
colorder_o  out  24  final column order
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE, k=0, all working registers 0, upd_req_o=0, out_valid_o=0, busy_o=0, in_ready_o=1.
- IDLE:
  - On start_i && in_ready_o: load H/norm/order from the inputs, k=0, go to PERM.
  - Otherwise start_i is ignored.
- PERM (exactly 1 cycle):
  - perm_N_o = 8-k.
  - Latch perm_H_i/perm_norm_i/perm_order_i into the working registers.
  - Go to UPD.
- UPD:
  - upd_req_o=1 and upd_col_o=k, held stable until the first cycle with upd_ack_i=1.
  - On that ack cycle: latch upd_H_i into H and upd_norm_i into norms; order is unchanged; upd_req_o drops the next cycle.
  - Then: if k == NSTAGE-1, go to DONE; else k=k+1 and go to PERM.
  - upd_ack_i is ignored while upd_req_o=0.
  - An ack in the same cycle the request is first raised is legal (minimum 1 cycle in UPD).
- DONE:
  - out_valid_o=1 with Hmatrix_o/colorder_o stable.
  - On out_ready_i, go to IDLE the next cycle; out_valid_o drops.
  - Back-pressure is unbounded; the registers hold.
- Latency per channel: 1 (load) + NSTAGE*(1 PERM + U_k UPD cycles) to out_valid_o, where U_k ≥ 1 is the engine's per-stage latency. With a 1-cycle engine and NSTAGE=7, out_valid_o rises 15 cycles after the accept edge.
- perm_*_o and upd_H_o always mirror the working registers; the datapaths see them in every state.
- Colnorm slots below index 8-N are never modified by the sequencer except via upd_norm_i.
- Reset mid-operation: immediately returns to IDLE with reset values. No partial result is emitted; upd_req_o drops asynchronously.
- Simultaneous start_i during a busy state: ignored (in_ready_o=0). No queuing.
- k is 3 bits; it never wraps because the exit check occurs at NSTAGE-1 ≤ 6.

Optional Feature:
- Macro SQRD_SWAP_CNT_EN.
- When defined:
  - Adds output swap_cnt_o[2:0], reset 0 and cleared on accept.
  - In each PERM cycle it increments when perm_order_i slot (8-N) differs from perm_order_o slot (8-N), i.e. a real column exchange occurred.
  - Valid with out_valid_o and saturates at 7.
- When undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Identity case: colorder_i={7..0}, colnorm slot j = j+1 (slot 0 smallest), 1-cycle engine echoing inputs -> out_valid_o 15 cycles after accept; colorder_o unchanged; swap_cnt_o=0 if enabled.
- Reverse norms: slot j norm = 8-j, model permutation datapath and engine -> 7 PERM cycles with perm_N_o 8,7,...,2; upd_col_o 0..6; colorder_o matches the golden SQRD model.
- Engine stall: upd_ack_i delayed 5 cycles at k=3 -> upd_req_o/upd_col_o=3 held for 5 cycles; extra stray ack pulses in PERM/DONE have no effect.
- Back-pressure: out_ready_i low for 10 cycles -> out_valid_o and outputs stable; start_i pulses ignored; in_ready_o=0 until 1 cycle after the handshake.
- Reset mid-run: rst asserted in UPD at k=2 -> upd_req_o=0, busy_o=0, in_ready_o=1 immediately; a following start runs a full clean sequence.
- NSTAGE=1 build: accept -> one PERM with perm_N_o=8, one UPD, then DONE.
